// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: default geometry,
// stack-pointer preload constants and the INIT/RUN state encoding.
package regfile_pkg;

  localparam int          DEF_WIDTH    = 32;
  localparam int          DEF_DEPTH    = 32;
  localparam int          DEF_NUM_READ = 2;
  localparam int          DEF_SP_INDEX = 29;
  localparam logic [31:0] DEF_SP_INIT  = 32'h0000_7FFF;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: forces zero while the clear sweep runs and
// for register 0, otherwise returns the stored word. When
// REGFILE_MULTIPORT_BYPASS_EN is defined, a same-cycle write to the read
// address is forwarded (write port 1 before write port 0, matching the
// write priority).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  stored,
  input  logic              run,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [WIDTH-1:0]  wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [WIDTH-1:0]  wd1,
  output logic [WIDTH-1:0]  data
);

`ifndef REGFILE_MULTIPORT_BYPASS_EN
  // Write-port inputs only feed the forwarding path, absent in this build.
  logic unused_bypass_s;
  assign unused_bypass_s = ^{we0, wa0, wd0, we1, wa1, wd1};
`endif

  // Read mux: sweep and register-0 zeroing, optional forwarding, storage.
  always_comb begin
    data = {WIDTH{1'b0}};
    if (!run) begin
      data = {WIDTH{1'b0}};
    end else if (addr == {ADDR_W{1'b0}}) begin
      data = {WIDTH{1'b0}};
`ifdef REGFILE_MULTIPORT_BYPASS_EN
    end else if (we1 && (wa1 == addr)) begin
      data = wd1;
    end else if (we0 && (wa0 == addr)) begin
      data = wd0;
`endif
    end else begin
      data = stored;
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_multiport.sv
// Parametrised register file: NUM_READ asynchronous read ports, two
// synchronous write ports (port 1 wins on an address collision), register 0
// hardwired to zero. After Reset a sweep clears one entry per clock and
// preloads SP_INDEX with SP_INIT; Ready rises when the sweep finishes and
// writes are accepted only from then on.
// Optional build macro: REGFILE_MULTIPORT_BYPASS_EN (same-cycle write-to-read
// forwarding, implemented inside regfile_read_port).
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int          WIDTH    = DEF_WIDTH,
  parameter int          DEPTH    = DEF_DEPTH,
  parameter int          NUM_READ = DEF_NUM_READ,
  parameter int          SP_INDEX = DEF_SP_INDEX,
  parameter logic [31:0] SP_INIT  = DEF_SP_INIT,
  localparam int         ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_READ*ADDR_W-1:0] ReadRegister,
  output logic [NUM_READ*WIDTH-1:0]  ReadData,
  input  logic [ADDR_W-1:0]          WriteRegister0,
  input  logic [WIDTH-1:0]           WriteData0,
  input  logic                       RegWrite0,
  input  logic [ADDR_W-1:0]          WriteRegister1,
  input  logic [WIDTH-1:0]           WriteData1,
  input  logic                       RegWrite1,
  output logic                       Ready
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_INDEX);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
  localparam logic [WIDTH-1:0]  SP_WORD   = WIDTH'(SP_INIT);

  rf_state_t         state_r;
  rf_state_t         state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_s;
  logic              ready_r;
  logic              ready_s;
  logic              run_s;
  logic              wr0_ok_s;
  logic              wr1_ok_s;

  logic [WIDTH-1:0]  mem_r [DEPTH];

  // Sweep sequencing: advance the pointer in INIT, enter RUN after the last entry.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    ready_s = ready_r;
    case (state_r)
      INIT: begin
        ptr_s = ptr_r + ONE_ADDR;
        if (ptr_r == LAST_ADDR) begin
          state_s = RUN;
          ready_s = 1'b1;
        end else begin
          state_s = INIT;
          ready_s = 1'b0;
        end
      end
      RUN: begin
        state_s = RUN;
        ready_s = 1'b1;
      end
      default: begin
        state_s = INIT;
        ptr_s   = ZERO_ADDR;
        ready_s = 1'b0;
      end
    endcase
  end

  // Control registers; Reset restarts the sweep from entry 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= INIT;
      ptr_r   <= ZERO_ADDR;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      ready_r <= ready_s;
    end
  end

  assign run_s    = (state_r == RUN);
  assign wr0_ok_s = RegWrite0 && (WriteRegister0 != ZERO_ADDR);
  assign wr1_ok_s = RegWrite1 && (WriteRegister1 != ZERO_ADDR);
  assign Ready    = ready_r;

  // Storage update: sweep writes in INIT, port writes in RUN with port 1
  // last so it overrides port 0 on the same address; untouched on Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // storage keeps its contents; the sweep that follows rewrites it
    end else if (!run_s) begin
      mem_r[ptr_r] <= (ptr_r == SP_ADDR) ? SP_WORD : {WIDTH{1'b0}};
    end else begin
      if (wr0_ok_s) begin
        mem_r[WriteRegister0] <= WriteData0;
      end
      if (wr1_ok_s) begin
        mem_r[WriteRegister1] <= WriteData1;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [WIDTH-1:0]  stored_s;

    assign addr_s   = ReadRegister[k*ADDR_W +: ADDR_W];
    assign stored_s = mem_r[addr_s];

    regfile_read_port #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .addr   (addr_s),
      .stored (stored_s),
      .run    (run_s),
      .we0    (RegWrite0),
      .wa0    (WriteRegister0),
      .wd0    (WriteData0),
      .we1    (RegWrite1),
      .wa1    (WriteRegister1),
      .wd1    (WriteData1),
      .data   (ReadData[k*WIDTH +: WIDTH])
    );
  end : g_rd

endmodule : regfile_multiport

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (4 read ports, 32x32). The stimulus
// process drives inputs just after each rising edge and pushes the expected
// Ready/ReadData for that cycle; a monitor pops and compares on the falling
// edge. The reference model treats the sweep as a whole: DEPTH edges after
// reset release the file becomes ready with every entry zero except SP.
module tb_regfile_multiport;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [NR*AW-1:0] ReadRegister;
  logic [NR*W-1:0]  ReadData;
  logic [AW-1:0]   WriteRegister0;
  logic [W-1:0]    WriteData0;
  logic            RegWrite0;
  logic [AW-1:0]   WriteRegister1;
  logic [W-1:0]    WriteData1;
  logic            RegWrite1;
  logic            Ready;

  always #5 Clk = ~Clk;

  regfile_multiport #(.NUM_READ(NR)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ReadRegister   (ReadRegister),
    .ReadData       (ReadData),
    .WriteRegister0 (WriteRegister0),
    .WriteData0     (WriteData0),
    .RegWrite0      (RegWrite0),
    .WriteRegister1 (WriteRegister1),
    .WriteData1     (WriteData1),
    .RegWrite1      (RegWrite1),
    .Ready          (Ready)
  );

  typedef struct {
    logic           rdy;
    logic [NR*W-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [W-1:0] mdl_mem [D];
  bit           mdl_ready = 1'b0;
  int           mdl_cnt   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
    if (!mdl_ready || a == 0) return '0;
`ifdef REGFILE_MULTIPORT_BYPASS_EN
    if (RegWrite1 && WriteRegister1 == a) return WriteData1;
    if (RegWrite0 && WriteRegister0 == a) return WriteData0;
`endif
    return mdl_mem[a];
  endfunction

  task automatic push_expect();
    exp_t e;
    e.rdy = mdl_ready;
    for (int k = 0; k < NR; k++) e.rd[k*W +: W] = exp_read(ReadRegister[k*AW +: AW]);
    exp_q.push_back(e);
  endtask

  // Effect of one rising edge on the reference model, from current inputs.
  task automatic model_edge();
    if (Reset) begin
      mdl_ready = 1'b0;
      mdl_cnt   = 0;
    end else if (!mdl_ready) begin
      mdl_cnt++;
      if (mdl_cnt == D) begin
        mdl_ready = 1'b1;
        for (int i = 0; i < D; i++) mdl_mem[i] = '0;
        mdl_mem[29] = 32'h0000_7FFF;
      end
    end else begin
      if (RegWrite0 && WriteRegister0 != 0) mdl_mem[WriteRegister0] = WriteData0;
      if (RegWrite1 && WriteRegister1 != 0) mdl_mem[WriteRegister1] = WriteData1;
    end
  endtask

  task automatic tick();
    push_expect();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic set_reads(input int a0, input int a1, input int a2, input int a3);
    ReadRegister = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle_writes();
    RegWrite0 = 1'b0; RegWrite1 = 1'b0;
    WriteRegister0 = '0; WriteRegister1 = '0;
    WriteData0 = '0; WriteData1 = '0;
  endtask

  // Ticks until the DUT raises Ready (bounded); returns the number of edges.
  task automatic wait_ready(output int n);
    n = 0;
    while (Ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation.
  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ready", W'(Ready), W'(e.rdy));
      for (int k = 0; k < NR; k++)
        check($sformatf("rdata%0d", k), ReadData[k*W +: W], e.rd[k*W +: W]);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    Reset = 1'b1;
    idle_writes();
    set_reads(29, 5, 0, 31);
    @(posedge Clk);
    model_edge();
    #1;

    // Sweep after a 1-cycle reset: Ready low for exactly 32 edges.
    Reset = 1'b0;
    wait_ready(n);
    check("ready_latency", W'(n), W'(32));
    tick();  // r29=7FFF, r5=0, r0=0, r31=0

    // Write r5 on port 0; pre-edge read shows old value or bypassed data.
    RegWrite0 = 1'b1; WriteRegister0 = 5'd5; WriteData0 = 32'hDEAD_BEEF;
    set_reads(5, 29, 5, 0);
    tick();
    idle_writes();
    tick();

    // Collision on r7: port 1 wins.
    RegWrite0 = 1'b1; WriteRegister0 = 5'd7; WriteData0 = 32'h0000_1111;
    RegWrite1 = 1'b1; WriteRegister1 = 5'd7; WriteData1 = 32'h0000_2222;
    set_reads(7, 7, 5, 1);
    tick();
    // Separate addresses r8/r9 in one cycle.
    WriteRegister0 = 5'd8; WriteData0 = 32'h0808_0808;
    WriteRegister1 = 5'd9; WriteData1 = 32'h0909_0909;
    set_reads(8, 9, 7, 8);
    tick();
    idle_writes();
    tick();

    // Writes to r0 from both ports never become visible.
    RegWrite0 = 1'b1; WriteRegister0 = 5'd0; WriteData0 = 32'hFFFF_FFFF;
    RegWrite1 = 1'b1; WriteRegister1 = 5'd0; WriteData1 = 32'hFFFF_FFFF;
    set_reads(0, 0, 0, 0);
    tick();
    idle_writes();
    tick();

    // Write during INIT is dropped.
    Reset = 1'b1; tick(); Reset = 1'b0;
    set_reads(3, 29, 5, 7);
    for (int i = 0; i < 10; i++) tick();
    RegWrite0 = 1'b1; WriteRegister0 = 5'd3; WriteData0 = 32'h0000_00AB;
    tick();
    idle_writes();
    wait_ready(n);
    check("ready_latency_init_write", W'(n), W'(21));
    tick();

    // Reset mid-sweep restarts the full 32-edge sweep.
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    wait_ready(n);
    check("ready_latency_restart", W'(n), W'(32));
    tick();

    // Randomised traffic, including collisions, bypass hits and rare resets.
    for (int i = 0; i < 400; i++) begin
      Reset          = ($urandom_range(0, 149) == 0);
      RegWrite0      = 1'($urandom_range(0, 1));
      RegWrite1      = 1'($urandom_range(0, 1));
      WriteRegister0 = AW'($urandom_range(0, D - 1));
      WriteRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister0
                                                   : AW'($urandom_range(0, D - 1));
      WriteData0     = $urandom;
      WriteData1     = $urandom;
      for (int k = 0; k < NR; k++) begin
        case ($urandom_range(0, 3))
          0:       ReadRegister[k*AW +: AW] = WriteRegister0;
          1:       ReadRegister[k*AW +: AW] = WriteRegister1;
          default: ReadRegister[k*AW +: AW] = AW'($urandom_range(0, D - 1));
        endcase
      end
      tick();
    end
    Reset = 1'b0;
    idle_writes();
    tick();

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile_multiport
